// File: rtl/route_loopback_pkg.sv
// Shared definitions for the routing-arc loopback checker.
//
// Contents:
//   state_e      - sequencer states (IDLE, LOAD, PRIME, CHECK, NEXT, DONE)
//   PRBS_W       - PRBS7 register width
//   PRBS_TAP_A/B - feedback tap positions for x^7 + x^6 + 1
//   PRBS_SEED    - value the generator restarts from for every lane
//   idxWidth()   - width of an index/counter able to hold 0..n-1, never less than 1
package route_loopback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRIME,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam int PRBS_W     = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;

  localparam logic [PRBS_W-1:0] PRBS_SEED = 7'h01;

  // A single-entry range still needs one bit of storage, so clamp at 1.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/route_prbs7_gen.sv
// PRBS7 stimulus source shared by every loopback lane.
//
// Fibonacci LFSR for x^7 + x^6 + 1, shifting left; the new LSB is
// bit6 ^ bit5 and the emitted bit is the MSB.
//
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset (register returns to the seed)
//   load    in  reload the seed on the next edge (wins over advance)
//   advance in  step the sequence on the next edge
//   bit_o   out current stimulus bit (register MSB)
module route_prbs7_gen
  import route_loopback_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic bit_o
);

  logic [PRBS_W-1:0] lfsr_q;
  logic [PRBS_W-1:0] lfsr_d;

  // Next LFSR value: reload takes priority so every lane starts from the
  // same point of the sequence, otherwise shift in the feedback bit.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = PRBS_SEED;
    end else if (advance) begin
      lfsr_d = {lfsr_q[PRBS_W-2:0], lfsr_q[PRBS_TAP_A] ^ lfsr_q[PRBS_TAP_B]};
    end
  end

  // LFSR register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= PRBS_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[PRBS_W-1];

endmodule

// File: rtl/route_loopback_sequencer.sv
// Scheduler that tests NUM_ROUTES routed loopback arcs one after another
// from a single PRBS7 source. For each lane it primes the path for PATH_LAT
// cycles, then compares TEST_LEN returned bits against a delayed copy of the
// transmitted stream, and finally records whether that lane saw any error.
//
// Optional build macro: ROUTE_LOOPBACK_FIRST_ERR_EN adds capture of the lane
// and CHECK-cycle index of the first mismatch of the sweep.
//
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   start           in   one-cycle pulse, starts a sweep from IDLE or DONE
//   lane_sel_o      out  one-hot enable of the lane being exercised
//   tx_o            out  stimulus bit driven into the selected route
//   rx_i            in   returned bits, one per lane
//   busy            out  sweep in progress
//   done            out  sweep finished, held until the next accepted start
//   fail_mask       out  bit i set when lane i saw at least one mismatch
//   err_count       out  saturating total of mismatches across the sweep
//   first_err_valid out  (macro only) a mismatch has been captured
//   first_err_lane  out  (macro only) lane of the first mismatch
//   first_err_bit   out  (macro only) CHECK index of the first mismatch
module route_loopback_sequencer
  import route_loopback_pkg::*;
#(
  parameter int NUM_ROUTES = 8,
  parameter int PATH_LAT   = 2,
  parameter int TEST_LEN   = 256,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [NUM_ROUTES-1:0] lane_sel_o,
  output logic                  tx_o,
  input  logic [NUM_ROUTES-1:0] rx_i,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_ROUTES-1:0] fail_mask,
  output logic [CNT_W-1:0]      err_count
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
  ,
  output logic                              first_err_valid,
  output logic [idxWidth(NUM_ROUTES)-1:0]   first_err_lane,
  output logic [idxWidth(TEST_LEN)-1:0]     first_err_bit
`endif
);

  localparam int LANE_W = idxWidth(NUM_ROUTES);
  localparam int CYC_W  = idxWidth((TEST_LEN > PATH_LAT) ? TEST_LEN : PATH_LAT);

  state_e                  state_q, state_d;
  logic [LANE_W-1:0]       laneIdx_q, laneIdx_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic                    laneErr_q, laneErr_d;
  logic [NUM_ROUTES-1:0]   failMask_q, failMask_d;
  logic [CNT_W-1:0]        errCount_q, errCount_d;

  logic prbsLoad;
  logic prbsAdvance;
  logic prbsBit;
  logic expBit;
  logic rxBit;
  logic mismatch;

  route_prbs7_gen u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (prbsLoad),
    .advance (prbsAdvance),
    .bit_o   (prbsBit)
  );

  // The stream only reaches the route while priming or checking; LOAD and
  // NEXT drive a quiet zero so consecutive lanes are separated by idle bits.
  assign tx_o = ((state_q == ST_PRIME) || (state_q == ST_CHECK)) ? prbsBit : 1'b0;

  // Reference for the returned bit: the transmitted stream delayed by the
  // path latency. With zero latency the current bit is the reference.
  generate
    if (PATH_LAT == 0) begin : gNoDelay
      assign expBit = tx_o;
    end else begin : gDelay
      logic [PATH_LAT-1:0] dly_q;
      logic [PATH_LAT-1:0] dly_d;

      // Shift line of transmitted bits, emptied when a new lane is loaded
      // so nothing from the previous lane leaks into the comparison.
      always_comb begin
        dly_d = PATH_LAT'({dly_q, tx_o});
        if (state_q == ST_LOAD) begin
          dly_d = '0;
        end
      end

      // Delay line register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_q <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign expBit = dly_q[PATH_LAT-1];
    end
  endgenerate

  assign rxBit    = rx_i[laneIdx_q];
  assign mismatch = (state_q == ST_CHECK) && (rxBit != expBit);

  // Next-state and output logic. Results are cleared on the same edge that
  // accepts start; a saturated error counter stops counting but the lane
  // flag still records the error so fail_mask stays accurate.
  always_comb begin
    state_d     = state_q;
    laneIdx_d   = laneIdx_q;
    cyc_d       = cyc_q;
    laneErr_d   = laneErr_q;
    failMask_d  = failMask_q;
    errCount_d  = errCount_q;
    prbsLoad    = 1'b0;
    prbsAdvance = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    lane_sel_o  = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          state_d    = ST_LOAD;
          laneIdx_d  = '0;
          cyc_d      = '0;
          laneErr_d  = 1'b0;
          failMask_d = '0;
          errCount_d = '0;
        end
      end

      ST_LOAD: begin
        busy       = 1'b1;
        lane_sel_o = NUM_ROUTES'(1) << laneIdx_q;
        prbsLoad   = 1'b1;
        cyc_d      = '0;
        state_d    = (PATH_LAT > 0) ? ST_PRIME : ST_CHECK;
      end

      ST_PRIME: begin
        busy        = 1'b1;
        lane_sel_o  = NUM_ROUTES'(1) << laneIdx_q;
        prbsAdvance = 1'b1;
        if (cyc_q == CYC_W'(PATH_LAT - 1)) begin
          cyc_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      ST_CHECK: begin
        busy        = 1'b1;
        lane_sel_o  = NUM_ROUTES'(1) << laneIdx_q;
        prbsAdvance = 1'b1;
        if (mismatch) begin
          laneErr_d = 1'b1;
          if (errCount_q != '1) begin
            errCount_d = errCount_q + 1'b1;
          end
        end
        if (cyc_q == CYC_W'(TEST_LEN - 1)) begin
          cyc_d   = '0;
          state_d = ST_NEXT;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      ST_NEXT: begin
        busy                  = 1'b1;
        failMask_d[laneIdx_q] = laneErr_q;
        laneErr_d             = 1'b0;
        if (laneIdx_q == LANE_W'(NUM_ROUTES - 1)) begin
          state_d = ST_DONE;
        end else begin
          laneIdx_d = laneIdx_q + 1'b1;
          state_d   = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      laneIdx_q  <= '0;
      cyc_q      <= '0;
      laneErr_q  <= 1'b0;
      failMask_q <= '0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      laneIdx_q  <= laneIdx_d;
      cyc_q      <= cyc_d;
      laneErr_q  <= laneErr_d;
      failMask_q <= failMask_d;
      errCount_q <= errCount_d;
    end
  end

  assign fail_mask = failMask_q;
  assign err_count = errCount_q;

`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
  localparam int BIT_W = idxWidth(TEST_LEN);

  logic              startAccept;
  logic              firstValid_q;
  logic [LANE_W-1:0] firstLane_q;
  logic [BIT_W-1:0]  firstBit_q;

  assign startAccept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Sticky capture of the first mismatch; only a new sweep or reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      firstValid_q <= 1'b0;
      firstLane_q  <= '0;
      firstBit_q   <= '0;
    end else if (startAccept) begin
      firstValid_q <= 1'b0;
      firstLane_q  <= '0;
      firstBit_q   <= '0;
    end else if (mismatch && !firstValid_q) begin
      firstValid_q <= 1'b1;
      firstLane_q  <= laneIdx_q;
      firstBit_q   <= BIT_W'(cyc_q);
    end
  end

  assign first_err_valid = firstValid_q;
  assign first_err_lane  = firstLane_q;
  assign first_err_bit   = firstBit_q;
`endif

endmodule

// File: tb/tb_route_loopback_sequencer.sv
// Randomised scoreboard bench for route_loopback_sequencer.
// Instance A uses the default parameters; instance B uses CNT_W=4,
// PATH_LAT=0 and a short TEST_LEN to reach saturation and the zero-latency
// path. A behavioural loopback drives rx_i from tx_o history with per-lane
// faults; a reference model predicts each sweep's results from the PRBS7
// sequence directly, and per-instance monitors compare when done rises.
module tb_route_loopback_sequencer;

  localparam int N    = 8;
  localparam int PA   = 2;
  localparam int TA   = 256;
  localparam int CA   = 16;
  localparam int PB   = 0;
  localparam int TB   = 32;
  localparam int CB   = 4;
  localparam int SMAX = 512;

  typedef struct {
    logic [N-1:0] mask;
    int           errs;
    int           lat;
    int           startCyc;
    bit           fv;
    int           fl;
    int           fb;
  } expect_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstA, rstB, startA, startB;
  logic [N-1:0]  laneSelA, laneSelB, rxA, rxB, failA, failB;
  logic          txA, txB, busyA, busyB, doneA, doneB;
  logic [CA-1:0] errA;
  logic [CB-1:0] errB;
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
  logic       fvA, fvB;
  logic [2:0] flA, flB;
  logic [7:0] fbA;
  logic [4:0] fbB;
`endif

  route_loopback_sequencer #(.NUM_ROUTES(N), .PATH_LAT(PA), .TEST_LEN(TA), .CNT_W(CA)) dutA (
    .clk(clk), .rst(rstA), .start(startA), .lane_sel_o(laneSelA), .tx_o(txA), .rx_i(rxA),
    .busy(busyA), .done(doneA), .fail_mask(failA), .err_count(errA)
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
    , .first_err_valid(fvA), .first_err_lane(flA), .first_err_bit(fbA)
`endif
  );

  route_loopback_sequencer #(.NUM_ROUTES(N), .PATH_LAT(PB), .TEST_LEN(TB), .CNT_W(CB)) dutB (
    .clk(clk), .rst(rstB), .start(startB), .lane_sel_o(laneSelB), .tx_o(txB), .rx_i(rxB),
    .busy(busyB), .done(doneB), .fail_mask(failB), .err_count(errB)
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
    , .first_err_valid(fvB), .first_err_lane(flB), .first_err_bit(fbB)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Loopback configuration per instance: mode 0 ideal, 1 stuck-0,
  // 2 stuck-1, 3 ideal with one bit inverted at CHECK index flipAt.
  int pl[2]   = '{PA, PB};
  int tl[2]   = '{TA, TB};
  int cw[2]   = '{CA, CB};
  int dly[2]  = '{PA, PB};
  int mode[2][N];
  int flipAt[2][N];
  int age[2][N];
  logic [15:0] hist[2];
  logic        sArr[SMAX];

  expect_t qA[$];
  expect_t qB[$];
  logic    prevDoneA = 1'b0;
  logic    prevDoneB = 1'b0;

  always @(posedge clk) cyc++;

  // PRBS7 bit j as seen on tx_o, counting from the first PRIME cycle.
  initial begin
    logic [6:0] s;
    s = 7'h01;
    for (int j = 0; j < SMAX; j++) begin
      sArr[j] = s[6];
      s = {s[5:0], s[6] ^ s[5]};
    end
  end

  function automatic logic loopBit(input int inst, input int l, input logic [15:0] h);
    logic b;
    case (mode[inst][l])
      1: b = 1'b0;
      2: b = 1'b1;
      default: begin
        b = h[dly[inst]];
        if (mode[inst][l] == 3 && age[inst][l] == 1 + pl[inst] + flipAt[inst][l]) b = ~b;
      end
    endcase
    return b;
  endfunction

  // Behavioural loopback: record tx_o mid-cycle and present the bit from
  // dly cycles ago, so the DUT samples it at the end of this cycle.
  always @(negedge clk) begin
    hist[0] = {hist[0][14:0], txA};
    hist[1] = {hist[1][14:0], txB};
    for (int l = 0; l < N; l++) begin
      age[0][l] = laneSelA[l] ? age[0][l] + 1 : -1;
      age[1][l] = laneSelB[l] ? age[1][l] + 1 : -1;
      rxA[l] = loopBit(0, l, hist[0]);
      rxB[l] = loopBit(1, l, hist[1]);
    end
  end

  // Reference model: compares what each lane returns against the stream
  // delayed by the DUT's path latency, summed over all lanes.
  function automatic expect_t predict(input int inst);
    expect_t e;
    int total, idx, sat;
    logic refBit, ret;
    e.mask = '0; e.fv = 1'b0; e.fl = 0; e.fb = 0; e.startCyc = 0;
    total = 0;
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < tl[inst]; k++) begin
        refBit = sArr[k];
        case (mode[inst][l])
          1: ret = 1'b0;
          2: ret = 1'b1;
          default: begin
            idx = pl[inst] + k - dly[inst];
            ret = (idx >= 0) ? sArr[idx] : 1'b0;
            if (mode[inst][l] == 3 && k == flipAt[inst][l]) ret = ~ret;
          end
        endcase
        if (ret !== refBit) begin
          total++;
          e.mask[l] = 1'b1;
          if (!e.fv) begin e.fv = 1'b1; e.fl = l; e.fb = k; end
        end
      end
    end
    sat    = (1 << cw[inst]) - 1;
    e.errs = (total > sat) ? sat : total;
    e.lat  = N * (2 + pl[inst] + tl[inst]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  task automatic checkSweep(input string tag, input expect_t e, input logic [N-1:0] mask,
                            input logic [63:0] err, input logic bsy,
                            input logic fv, input logic [63:0] fl, input logic [63:0] fb);
    checkOutput({tag, "_done_latency"}, 64'(cyc - e.startCyc), 64'(e.lat));
    checkOutput({tag, "_fail_mask"}, 64'(mask), 64'(e.mask));
    checkOutput({tag, "_err_count"}, err, 64'(e.errs));
    checkOutput({tag, "_busy_at_done"}, 64'(bsy), 64'(0));
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
    checkOutput({tag, "_first_err_valid"}, 64'(fv), 64'(e.fv));
    if (e.fv) begin
      checkOutput({tag, "_first_err_lane"}, fl, 64'(e.fl));
      checkOutput({tag, "_first_err_bit"}, fb, 64'(e.fb));
    end
`endif
  endtask

  // Monitors: pop and compare when done rises on each instance.
  always @(negedge clk) begin : monA
    expect_t e;
    if (doneA && !prevDoneA) begin
      if (qA.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL A_unexpected_done: got done=1, wanted no pending sweep");
      end else begin
        e = qA.pop_front();
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
        checkSweep("A", e, failA, 64'(errA), busyA, fvA, 64'(flA), 64'(fbA));
`else
        checkSweep("A", e, failA, 64'(errA), busyA, 1'b0, 64'(0), 64'(0));
`endif
      end
    end
    prevDoneA = doneA;
  end

  always @(negedge clk) begin : monB
    expect_t e;
    if (doneB && !prevDoneB) begin
      if (qB.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL B_unexpected_done: got done=1, wanted no pending sweep");
      end else begin
        e = qB.pop_front();
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
        checkSweep("B", e, failB, 64'(errB), busyB, fvB, 64'(flB), 64'(fbB));
`else
        checkSweep("B", e, failB, 64'(errB), busyB, 1'b0, 64'(0), 64'(0));
`endif
      end
    end
    prevDoneB = doneB;
  end

  task automatic setClean(input int inst);
    for (int l = 0; l < N; l++) begin mode[inst][l] = 0; flipAt[inst][l] = 0; end
    dly[inst] = pl[inst];
  endtask

  task automatic setRandom(input int inst);
    for (int l = 0; l < N; l++) begin
      mode[inst][l]   = int'($urandom_range(0, 3));
      flipAt[inst][l] = int'($urandom_range(0, tl[inst] - 1));
    end
    dly[inst] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : pl[inst];
    if (dly[inst] < 0) dly[inst] = 0;
  endtask

  // Predict the sweep, queue the expectation, then pulse start.
  task automatic applyStimulus(input int inst);
    expect_t e;
    e = predict(inst);
    @(negedge clk);
    e.startCyc = cyc + 1;
    if (inst == 0) begin qA.push_back(e); startA = 1'b1; end
    else           begin qB.push_back(e); startB = 1'b1; end
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDrain(input int inst, input int limit);
    int n = 0;
    while (((inst == 0) ? qA.size() : qB.size()) > 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (((inst == 0) ? qA.size() : qB.size()) > 0) begin
      vectors++; miscompares++;
      $display("[TB] FAIL %s_done_timeout: got no done after %0d cycles, wanted done", (inst == 0) ? "A" : "B", n);
      if (inst == 0) qA.delete(); else qB.delete();
    end
  endtask

  task automatic checkResetOutputsA(input string tag);
    checkOutput({tag, "_lane_sel"}, 64'(laneSelA), 64'(0));
    checkOutput({tag, "_tx"}, 64'(txA), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busyA), 64'(0));
    checkOutput({tag, "_done"}, 64'(doneA), 64'(0));
    checkOutput({tag, "_fail_mask"}, 64'(failA), 64'(0));
    checkOutput({tag, "_err_count"}, 64'(errA), 64'(0));
`ifdef ROUTE_LOOPBACK_FIRST_ERR_EN
    checkOutput({tag, "_first_err_valid"}, 64'(fvA), 64'(0));
`endif
  endtask

  initial begin
    int n;
    rstA = 1'b1; rstB = 1'b1; startA = 1'b0; startB = 1'b0;
    hist[0] = '0; hist[1] = '0;
    for (int l = 0; l < N; l++) begin age[0][l] = -1; age[1][l] = -1; end
    setClean(0);
    setClean(1);
    repeat (3) @(negedge clk);
    checkResetOutputsA("A_reset");
    checkOutput("B_reset_busy", 64'(busyB), 64'(0));
    rstA = 1'b0; rstB = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] clean sweep");
    setClean(0);
    applyStimulus(0); waitDrain(0, 3000);

    $display("[TB] lane 3 stuck at 0");
    setClean(0); mode[0][3] = 1;
    applyStimulus(0); waitDrain(0, 3000);

    $display("[TB] lane 5 single flip at CHECK index 10");
    setClean(0); mode[0][5] = 3; flipAt[0][5] = 10;
    applyStimulus(0); waitDrain(0, 3000);

    $display("[TB] path delay 3 against PATH_LAT 2");
    setClean(0); dly[0] = 3;
    applyStimulus(0); waitDrain(0, 3000);

    $display("[TB] reset during lane 4 CHECK");
    setClean(0); mode[0][2] = 1;
    applyStimulus(0);
    n = 0;
    while (!(laneSelA[4] && age[0][4] > PA + 20) && n < 3000) begin @(negedge clk); n++; end
    checkOutput("A_reached_lane4_check", 64'(laneSelA), 64'(8'h10));
    #2;
    rstA = 1'b1;
    #1;
    checkResetOutputsA("A_abort");
    qA.delete();
    repeat (2) @(negedge clk);
    rstA = 1'b0;
    setClean(0);
    applyStimulus(0); waitDrain(0, 3000);

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random sweep %0d on A", r);
      setRandom(0);
      applyStimulus(0); waitDrain(0, 3000);
    end

    $display("[TB] B lane 0 stuck at 1, start while busy");
    setClean(1); mode[1][0] = 2;
    applyStimulus(1);
    repeat (40) @(negedge clk);
    checkOutput("B_busy_midsweep", 64'(busyB), 64'(1));
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    waitDrain(1, 1000);

    $display("[TB] B clean and random sweeps");
    setClean(1);
    applyStimulus(1); waitDrain(1, 1000);
    setRandom(1);
    applyStimulus(1); waitDrain(1, 1000);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
